picoram_uart_tx: RTL and testbench
==================================

// Module: picoram_uart_tx
// PURPOSE
//   UART 8N1 transmitter for the picoram SoC; drives the ser_tx line toward the host or bench sampler.
//   Buffers bytes written by the CPU peripheral bus in a small FIFO.
//   Serializes each byte as one start bit, 8 data bits LSB first, and one stop bit.
//   The bit period is programmable in clock cycles, so it can match the bench sampler (2*53 = 106 clocks/bit).
// PARAMETERS
//   DIV_WIDTH   16   width of cfg_div
//   FIFO_DEPTH  4    TX FIFO entries; power of two, >= 2
//   LVL_WIDTH   3    width of fifo_level; must equal $clog2(FIFO_DEPTH)+1
// PORTS
//   clk         in   1          system clock, rising edge
//   reset       in   1          asynchronous reset, active-high
//   cfg_div     in   DIV_WIDTH  clocks per bit; values 0 and 1 are treated as 2
//   wr_valid    in   1          write strobe; byte accepted when wr_valid && wr_ready at clk rise
//   wr_data     in   8          byte to transmit
//   wr_ready    out  1          FIFO not full
//   ser_tx      out  1          serial line; idle high
//   busy        out  1          high while a frame is on the line or the FIFO is non-empty
//   fifo_level  out  LVL_WIDTH  number of bytes queued, excluding the byte being shifted
// BEHAVIOUR
//   Reset (async, takes effect immediately)
//     - ser_tx=1, busy=0, wr_ready=1, fifo_level=0.
//     - FIFO is emptied, state=IDLE, counters cleared.
//     - A frame in progress is aborted; the line returns high at once.
//   FIFO
//     - Write-pointer/read-pointer ring; pointers wrap modulo FIFO_DEPTH.
//     - wr_ready = (fifo_level != FIFO_DEPTH).
//     - A write while full is ignored (not stored), even if a pop occurs in the same cycle.
//     - A write and a pop in the same cycle leave the level unchanged.
//   State machine: IDLE -> START -> DATA -> STOP -> (START | IDLE)
//     - IDLE: ser_tx=1. If FIFO non-empty, then at the next edge:
//         pop head into shift reg, latch eff_div = max(cfg_div,2), clear bit counter, enter START.
//     - START: ser_tx=0 for eff_div cycles.
//     - DATA: ser_tx=shift[0] for eff_div cycles per bit, then shift right; 8 bits, LSB first.
//     - STOP: ser_tx=1 for eff_div cycles. At the end of STOP:
//         if FIFO non-empty, pop and latch as above and go directly to START (no idle gap);
//         else go to IDLE.
//   Timing
//     - Byte accepted at edge N into an empty FIFO while IDLE: ser_tx falls after edge N+1.
//     - A frame is exactly 10*eff_div cycles.
//     - cfg_div changes take effect only at the next frame start; the current frame is unaffected.
//     - Baud counter counts eff_div-1 down to 0; a bit transition occurs when it reaches 0.
//   Status
//     - busy = (state != IDLE) || (fifo_level != 0).
//     - fifo_level updates the cycle after the write/pop edge.
//   Outputs
//     - All outputs are registered except wr_ready and busy, which are decoded from registers.
// TESTING
//   1. cfg_div=106, write 0x55 -> ser_tx low 106 clocks after the accept edge +1;
//      bits 1,0,1,0,1,0,1,0 each 106 clocks; stop high; busy drops at 1060 clocks.
//   2. cfg_div=106, write 0x48,0x69 back-to-back -> a 53/106 sampler decodes 'H','i';
//      second start bit begins exactly at the end of the first stop bit.
//   3. cfg_div=4, hold wr_valid with 6 distinct bytes -> wr_ready low when fifo_level=4;
//      the byte offered while full is not sent; the transmitted order matches the accepted order.
//   4. Assert reset mid-DATA of 0xA3 -> ser_tx=1 the same cycle; fifo_level=0;
//      after release no residual frame is sent; the next write sends cleanly.
//   5. cfg_div=0 then cfg_div=1, write 0xFF -> 2 clocks per bit, 20-clock frame;
//      changing cfg_div mid-frame leaves the current frame's bit width unchanged.
//   6. Random 200 bytes, random cfg_div in 2..20 set between frames -> a bench sampler
//      decodes every byte in order; stop bit always 1.

Source files
------------

// File: rtl/picoram_uart_tx.sv
// UART 8N1 transmitter with a small TX FIFO and a programmable bit period.
// Bytes leave in the order they were accepted: start bit, 8 data bits LSB first, stop bit.
module picoram_uart_tx #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 wr_valid,
    input  logic [7:0]           wr_data,
    output logic                 wr_ready,
    output logic                 ser_tx,
    output logic                 busy,
    output logic [LVL_WIDTH-1:0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] eff_div;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [DIV_WIDTH-1:0] next_div;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 bit_end;

    // Write handshake: a byte is taken on the rising edge where wr_valid && wr_ready;
    // wr_ready depends only on the level, so a pop in the same cycle cannot admit a write into a full FIFO.
    assign wr_ready   = (fifo_level != LVL_WIDTH'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign fifo_empty = (fifo_level == '0);
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign bit_end    = (baud_cnt == '0);
    assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign next_div   = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // A pop always starts a fresh frame, whether from IDLE or straight out of STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ser_tx   <= 1'b1;
            shift    <= '0;
            eff_div  <= DIV_WIDTH'(2);
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (pop) begin
            state    <= S_START;
            ser_tx   <= 1'b0;
            shift    <= mem[rd_ptr];
            eff_div  <= next_div;
            baud_cnt <= next_div - 1'b1;
            bit_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ser_tx <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        ser_tx   <= shift[0];
                        baud_cnt <= eff_div - 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= eff_div - 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state  <= S_STOP;
                            ser_tx <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            ser_tx  <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ser_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picoram_uart_tx.sv
// Directed bench for picoram_uart_tx: cycle-exact line/status checks plus a serial
// sampler that decodes every frame against a queue of expected bytes.
`timescale 1ns/1ps
module tb_picoram_uart_tx;

    logic        clk;
    logic        reset;
    logic [15:0] cfg_div;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        ser_tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          exp_div = 2;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [7:0]  t3_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    picoram_uart_tx #(
        .DIV_WIDTH (16),
        .FIFO_DEPTH(4),
        .LVL_WIDTH (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_div   (cfg_div),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .ser_tx    (ser_tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        check("wr_ready_on_write", wr_ready, 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check("idle_timeout", busy, 0);
        step(2);
        check("rx_queue_drained", exp_q.size(), 0);
    endtask

    // Frame with cfg_div at 0 or 1 must run at 2 clocks per bit.
    task automatic short_div_frame(input logic [15:0] div);
        cfg_div = div;
        exp_div = 2;
        exp_q.push_back(8'hFF);
        write_byte(8'hFF);
        step(1);
        check("t5_start_fall", ser_tx, 0);
        step(2);
        check("t5_bit0_after_2", ser_tx, 1);
        step(17);
        check("t5_busy_at_20", busy, 1);
        step(1);
        check("t5_busy_drop_21", busy, 0);
        wait_idle(10);
    endtask

    // Serial sampler: centre-samples 10 bits using the bit period expected for this frame
    initial begin : sampler
        int d;
        int t;
        int st;
        logic [9:0] bits;
        logic aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && ser_tx === 1'b0) begin
                d       = exp_div;
                st      = cyc;
                t       = 0;
                aborted = 1'b0;
                bits    = '1;
                for (int b = 0; b < 10; b++) begin
                    while (!aborted && t < b * d + d / 2) begin
                        @(negedge clk);
                        t++;
                        if (reset !== 1'b0) aborted = 1'b1;
                    end
                    bits[b] = ser_tx;
                end
                if (!aborted) begin
                    start_q.push_back(st);
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[9], 1);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("rx_byte", bits[8:1], exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        cfg_div  = 16'd106;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        step(3);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_level", fifo_level, 0);
        reset = 1'b0;
        step(2);

        // 1: single 0x55 at 106 clocks/bit, exact edge placement
        exp_div = 106;
        exp_q.push_back(8'h55);
        write_byte(8'h55);
        check("t1_idle_at_accept", ser_tx, 1);
        check("t1_level_at_accept", fifo_level, 1);
        check("t1_busy_at_accept", busy, 1);
        step(1);
        check("t1_start_fall", ser_tx, 0);
        check("t1_level_after_pop", fifo_level, 0);
        step(105);
        check("t1_start_last", ser_tx, 0);
        step(1);
        check("t1_bit0", ser_tx, 1);
        step(953);
        check("t1_stop_high", ser_tx, 1);
        check("t1_busy_before_end", busy, 1);
        step(1);
        check("t1_busy_drop", busy, 0);
        wait_idle(10);

        // 2: 'H','i' back to back, second start right at end of first stop
        start_q.delete();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        write_byte(8'h48);
        write_byte(8'h69);
        check("t2_level_overlap", fifo_level, 1);
        wait_idle(2500);
        check("t2_frames", start_q.size(), 2);
        if (start_q.size() == 2) begin
            check("t2_gap", start_q[1] - start_q[0], 1060);
        end

        // 3: six bytes offered on consecutive cycles; the sixth meets a full FIFO
        cfg_div = 16'd4;
        exp_div = 4;
        for (int i = 0; i < 5; i++) exp_q.push_back(t3_bytes[i]);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = t3_bytes[i];
            check($sformatf("t3_ready_%0d", i), wr_ready, (i < 5));
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        check("t3_level_full", fifo_level, 4);
        check("t3_ready_full", wr_ready, 0);
        wait_idle(400);

        // 4: reset during bit 2 (a zero) of 0xA3 with another byte queued
        cfg_div = 16'd10;
        exp_div = 10;
        write_byte(8'hA3);
        write_byte(8'h3C);
        step(35);
        check("t4_mid_data_low", ser_tx, 0);
        check("t4_level_queued", fifo_level, 1);
        reset = 1'b1;
        #1;
        check("t4_rst_ser_tx", ser_tx, 1);
        check("t4_rst_level", fifo_level, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_ready", wr_ready, 1);
        step(2);
        reset = 1'b0;
        exp_q.delete();
        step(40);
        check("t4_quiet_line", ser_tx, 1);
        check("t4_quiet_busy", busy, 0);
        exp_q.push_back(8'h5A);
        write_byte(8'h5A);
        wait_idle(200);

        // 5: cfg_div 0 and 1 clamp to 2; mid-frame cfg_div change is ignored
        short_div_frame(16'd0);
        short_div_frame(16'd1);
        cfg_div = 16'd6;
        exp_div = 6;
        exp_q.push_back(8'h0F);
        write_byte(8'h0F);
        step(10);
        cfg_div = 16'd20;
        step(50);
        check("t5_mid_busy_at_60", busy, 1);
        step(1);
        check("t5_mid_busy_drop_61", busy, 0);
        wait_idle(10);

        // 6: 200 random bytes, random bit period per frame
        for (int i = 0; i < 200; i++) begin
            int d;
            logic [7:0] b;
            d = $urandom_range(20, 2);
            b = 8'($urandom_range(255, 0));
            cfg_div = 16'(d);
            exp_div = d;
            exp_q.push_back(b);
            write_byte(b);
            wait_idle(10 * d + 20);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
